// File: rtl/toysram_nr1w_ctl_if.sv
// Bus bundle for toysram_nr1w_ctl: init control, two read ports and one write port.
// Vectors are MSB-first ([0:N-1]); master drives requests, slave returns data and status.
interface toysram_nr1w_ctl_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             init_req;
    logic             init_busy;
    logic             rd_enb_0;
    logic             rd_enb_1;
    logic [0:AW-1]    rd_adr_0;
    logic [0:AW-1]    rd_adr_1;
    logic [0:WIDTH-1] rd_dat_0;
    logic [0:WIDTH-1] rd_dat_1;
    logic             rd_vld_0;
    logic             rd_vld_1;
    logic             wr_enb_0;
    logic [0:AW-1]    wr_adr_0;
    logic [0:WIDTH-1] wr_dat_0;

    modport master (
        output init_req, rd_enb_0, rd_enb_1, rd_adr_0, rd_adr_1,
               wr_enb_0, wr_adr_0, wr_dat_0,
        input  init_busy, rd_dat_0, rd_dat_1, rd_vld_0, rd_vld_1
    );

    modport slave (
        input  init_req, rd_enb_0, rd_enb_1, rd_adr_0, rd_adr_1,
               wr_enb_0, wr_adr_0, wr_dat_0,
        output init_busy, rd_dat_0, rd_dat_1, rd_vld_0, rd_vld_1
    );
endinterface

// File: rtl/toysram_nr1w_ctl.sv
// Two-read/one-write behavioural SRAM with registered inputs and a zero-fill init sequencer.
// Optional macro WR_BYPASS_EN forwards a same-cycle user write to matching reads.
module toysram_nr1w_ctl #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int LATCHRD = 1
) (
    input  logic              clk,
    input  logic              reset,
    toysram_nr1w_ctl_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, INIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic             rd_enb_p0_q [2];
    logic             rd_enb_p0_d [2];
    logic [0:AW-1]    rd_adr_p0_q [2];
    logic [0:AW-1]    rd_adr_p0_d [2];
    logic             wr_enb_p0_q, wr_enb_p0_d;
    logic [0:AW-1]    wr_adr_p0_q, wr_adr_p0_d;
    logic [0:WIDTH-1] wr_dat_p0_q, wr_dat_p0_d;

    logic [0:WIDTH-1] mem [DEPTH];
    logic             busy, init_we, wr_fire, mem_we;
    logic [AW-1:0]    mem_wa;
    logic [0:WIDTH-1] mem_wd;
    logic             rd_fire  [2];
    logic [0:WIDTH-1] rd_raw   [2];
    logic             rd_vld_o [2];
    logic [0:WIDTH-1] rd_dat_o [2];

    always_comb begin
        rd_enb_p0_d[0] = bus.rd_enb_0;
        rd_enb_p0_d[1] = bus.rd_enb_1;
        rd_adr_p0_d[0] = bus.rd_adr_0;
        rd_adr_p0_d[1] = bus.rd_adr_1;
        wr_enb_p0_d    = bus.wr_enb_0;
        wr_adr_p0_d    = bus.wr_adr_0;
        wr_dat_p0_d    = bus.wr_dat_0;
    end

    // Counter parks at DEPTH-1 after the last init write; it only restarts on a new init.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.init_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                init_we = 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = DONE;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            wr_enb_p0_q <= 1'b0;
            wr_adr_p0_q <= '0;
            wr_dat_p0_q <= '0;
            for (int p = 0; p < 2; p++) begin
                rd_enb_p0_q[p] <= 1'b0;
                rd_adr_p0_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_enb_p0_q <= wr_enb_p0_d;
            wr_adr_p0_q <= wr_adr_p0_d;
            wr_dat_p0_q <= wr_dat_p0_d;
            for (int p = 0; p < 2; p++) begin
                rd_enb_p0_q[p] <= rd_enb_p0_d[p];
                rd_adr_p0_q[p] <= rd_adr_p0_d[p];
            end
        end
    end

    // Stage p0 -> array: user traffic is squashed whenever the sequencer owns the array.
    always_comb begin
        busy    = (state_q != IDLE);
        wr_fire = wr_enb_p0_q && !busy;
        mem_we  = (init_we || wr_fire) && !reset;
        mem_wa  = init_we ? cnt_q : wr_adr_p0_q;
        mem_wd  = init_we ? '0 : wr_dat_p0_q;
        for (int p = 0; p < 2; p++) begin
            rd_fire[p] = rd_enb_p0_q[p] && !busy;
            rd_raw[p]  = mem[rd_adr_p0_q[p]];
`ifdef WR_BYPASS_EN
            if (wr_fire && (wr_adr_p0_q == rd_adr_p0_q[p])) rd_raw[p] = wr_dat_p0_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Stage p1: registered read data holds its value between valid reads.
    generate
        if (LATCHRD != 0) begin : g_latch
            logic             rd_vld_p1_q [2];
            logic             rd_vld_p1_d [2];
            logic [0:WIDTH-1] rd_dat_p1_q [2];
            logic [0:WIDTH-1] rd_dat_p1_d [2];

            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    rd_vld_p1_d[p] = rd_fire[p];
                    rd_dat_p1_d[p] = rd_fire[p] ? rd_raw[p] : rd_dat_p1_q[p];
                    rd_vld_o[p]    = rd_vld_p1_q[p];
                    rd_dat_o[p]    = rd_dat_p1_q[p];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int p = 0; p < 2; p++) begin
                        rd_vld_p1_q[p] <= 1'b0;
                        rd_dat_p1_q[p] <= '0;
                    end
                end else begin
                    for (int p = 0; p < 2; p++) begin
                        rd_vld_p1_q[p] <= rd_vld_p1_d[p];
                        rd_dat_p1_q[p] <= rd_dat_p1_d[p];
                    end
                end
            end
        end else begin : g_flow
            always_comb begin
                for (int p = 0; p < 2; p++) begin
                    rd_vld_o[p] = rd_fire[p];
                    rd_dat_o[p] = rd_fire[p] ? rd_raw[p] : '0;
                end
            end
        end
    endgenerate

    assign bus.init_busy = busy;
    assign bus.rd_vld_0  = rd_vld_o[0];
    assign bus.rd_vld_1  = rd_vld_o[1];
    assign bus.rd_dat_0  = rd_dat_o[0];
    assign bus.rd_dat_1  = rd_dat_o[1];

endmodule

// File: tb/tb_toysram_nr1w_ctl.sv
// Bench for toysram_nr1w_ctl: a 64x256 flow-through instance with directed checks, then a
// 32x32 registered-read instance driven randomly against a transaction-level memory model.
`timescale 1ns/1ps
module tb_toysram_nr1w_ctl;
    localparam int WA = 32, DA = 32, LA = 2;
    localparam int WB = 64, DB = 256;
`ifdef WR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;

    toysram_nr1w_ctl_if #(.WIDTH(WA), .DEPTH(DA)) ifa ();
    toysram_nr1w_ctl_if #(.WIDTH(WB), .DEPTH(DB)) ifb ();

    toysram_nr1w_ctl #(.WIDTH(WA), .DEPTH(DA), .LATCHRD(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ifa.slave));
    toysram_nr1w_ctl #(.WIDTH(WB), .DEPTH(DB), .LATCHRD(0)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb.slave));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model for instance A: memory image plus per-port queue of expected read returns.
    typedef struct packed { logic v; logic [31:0] d; } rd_t;
    logic [31:0] ref_mem [DA];
    rd_t         q0[$];
    rd_t         q1[$];
    logic [31:0] last_d [2];
    int          busy_rem;
    bit          in_rst;

    function automatic logic [31:0] rdval(input bit acc, input bit we, input logic [4:0] wa,
                                          input logic [31:0] wd, input logic [4:0] ra);
        if (BYPASS && acc && we && (wa == ra)) return wd;
        return ref_mem[ra];
    endfunction

    task automatic model_reset();
        in_rst   = 1'b1;
        busy_rem = DA + 1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < LA; i++) begin
            q0.push_back('0);
            q1.push_back('0);
        end
        last_d[0] = '0;
        last_d[1] = '0;
    endtask

    task automatic cycle_a(input bit rv, input bit ireq, input bit re0, input logic [4:0] ra0,
                           input bit re1, input logic [4:0] ra1, input bit we,
                           input logic [4:0] wa, input logic [31:0] wd);
        rd_t e0, e1;
        bit  acc;
        @(negedge clk);
        if (!in_rst && busy_rem > 0) busy_rem--;
        chk("busy", 64'(ifa.init_busy), 64'(busy_rem > 0));
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("vld0", 64'(ifa.rd_vld_0), 64'(e0.v));
        chk("vld1", 64'(ifa.rd_vld_1), 64'(e1.v));
        if (e0.v) last_d[0] = e0.d;
        if (e1.v) last_d[1] = e1.d;
        chk("dat0", 64'(ifa.rd_dat_0), 64'(last_d[0]));
        chk("dat1", 64'(ifa.rd_dat_1), 64'(last_d[1]));

        if (rv) begin
            rst_a = 1'b1;
            model_reset();
            ifa.init_req = 1'b0; ifa.rd_enb_0 = 1'b0; ifa.rd_enb_1 = 1'b0; ifa.wr_enb_0 = 1'b0;
            return;
        end
        if (in_rst) begin
            rst_a  = 1'b0;
            in_rst = 1'b0;
            for (int i = 0; i < DA; i++) ref_mem[i] = '0;
        end
        if (ireq && busy_rem == 0) begin
            busy_rem = DA + 2;
            for (int i = 0; i < DA; i++) ref_mem[i] = '0;
        end
        // An operation is honoured only if the array is free in the cycle after capture.
        acc  = !(busy_rem > 1);
        e0.v = acc && re0;
        e0.d = rdval(acc, we, wa, wd, ra0);
        e1.v = acc && re1;
        e1.d = rdval(acc, we, wa, wd, ra1);
        q0.push_back(e0);
        q1.push_back(e1);
        if (acc && we) ref_mem[wa] = wd;

        ifa.init_req = ireq;
        ifa.rd_enb_0 = re0; ifa.rd_adr_0 = ra0;
        ifa.rd_enb_1 = re1; ifa.rd_adr_1 = ra1;
        ifa.wr_enb_0 = we;  ifa.wr_adr_0 = wa; ifa.wr_dat_0 = wd;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) cycle_a(0, 0, 0, '0, 0, '0, 0, '0, '0);
    endtask

    task automatic count_busy_a(input string tag);
        int n;
        n = 0;
        #1;
        while (ifa.init_busy && n < 200) begin
            n++;
            idle_a(1);
        end
        chk(tag, 64'(n), 64'(DA + 1));
    endtask

    task automatic drive_b(input bit re0, input logic [7:0] ra0, input bit re1,
                           input logic [7:0] ra1, input bit we, input logic [7:0] wa,
                           input logic [63:0] wd);
        ifb.init_req = 1'b0;
        ifb.rd_enb_0 = re0; ifb.rd_adr_0 = ra0;
        ifb.rd_enb_1 = re1; ifb.rd_adr_1 = ra1;
        ifb.wr_enb_0 = we;  ifb.wr_adr_0 = wa; ifb.wr_dat_0 = wd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        logic [31:0] r;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.init_req = 1'b0; ifa.rd_enb_0 = 1'b0; ifa.rd_enb_1 = 1'b0; ifa.wr_enb_0 = 1'b0;
        ifa.rd_adr_0 = '0; ifa.rd_adr_1 = '0; ifa.wr_adr_0 = '0; ifa.wr_dat_0 = '0;
        drive_b(0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);

        // Instance B: flow-through reads, 256-entry array.
        repeat (3) @(negedge clk);
        chk("b_rst_busy", 64'(ifb.init_busy), 64'd1);
        chk("b_rst_vld0", 64'(ifb.rd_vld_0), 64'd0);
        chk("b_rst_dat0", ifb.rd_dat_0, 64'd0);
        rst_b = 1'b0;
        #1;
        n = 0;
        while (ifb.init_busy && n < 1000) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("b_init_cycles", 64'(n), 64'(DB + 1));

        drive_b(1, 8'd0, 1, 8'd255, 0, 8'd0, 64'd0);
        @(negedge clk);
        chk("b_zero_vld0", 64'(ifb.rd_vld_0), 64'd1);
        chk("b_zero_dat0", ifb.rd_dat_0, 64'd0);
        chk("b_zero_dat1", ifb.rd_dat_1, 64'd0);
        drive_b(0, 8'd0, 0, 8'd0, 1, 8'd255, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("b_nord_vld0", 64'(ifb.rd_vld_0), 64'd0);
        drive_b(1, 8'd255, 1, 8'd255, 0, 8'd0, 64'd0);
        @(negedge clk);
        chk("b_ones_vld0", 64'(ifb.rd_vld_0), 64'd1);
        chk("b_ones_vld1", 64'(ifb.rd_vld_1), 64'd1);
        chk("b_ones_dat0", ifb.rd_dat_0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_ones_dat1", ifb.rd_dat_1, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_b(1, 8'd7, 0, 8'd0, 1, 8'd7, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        chk("b_rbw_dat0", ifb.rd_dat_0, BYPASS ? 64'h0123_4567_89AB_CDEF : 64'd0);
        drive_b(0, 8'd0, 1, 8'd7, 0, 8'd0, 64'd0);
        @(negedge clk);
        chk("b_after_dat1", ifb.rd_dat_1, 64'h0123_4567_89AB_CDEF);
        drive_b(0, 8'd0, 0, 8'd0, 0, 8'd0, 64'd0);

        // Instance A: registered reads, model-checked every cycle.
        model_reset();
        cycle_a(1, 0, 0, '0, 0, '0, 0, '0, '0);
        cycle_a(1, 0, 0, '0, 0, '0, 0, '0, '0);
        cycle_a(0, 0, 0, '0, 0, '0, 0, '0, '0);
        count_busy_a("a_init_cycles");
        for (int i = 0; i < DA; i++) cycle_a(0, 0, 1, 5'(i), 1, 5'(DA - 1 - i), 0, '0, '0);
        idle_a(3);

        cycle_a(0, 0, 0, '0, 0, '0, 1, 5'd5, 32'hDEAD_BEEF);
        cycle_a(0, 0, 1, 5'd5, 1, 5'd5, 0, '0, '0);
        idle_a(3);
        cycle_a(0, 0, 1, 5'd7, 0, '0, 1, 5'd7, 32'h1234_5678);
        cycle_a(0, 0, 0, '0, 1, 5'd7, 0, '0, '0);
        idle_a(3);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            cycle_a(0, ($urandom_range(0, 149) == 0), r[0], r[1] ? 5'(r[10:8]) : r[15:11],
                    r[2], r[3] ? 5'(r[13:11]) : r[20:16], r[4], r[5] ? 5'(r[23:21]) : r[28:24],
                    $urandom);
        end
        idle_a(DA + 4);

        cycle_a(0, 0, 0, '0, 0, '0, 1, 5'd31, 32'hA5A5_A5A5);
        cycle_a(0, 0, 1, 5'd31, 0, '0, 0, '0, '0);
        idle_a(3);
        cycle_a(0, 1, 0, '0, 0, '0, 0, '0, '0);
        idle_a(5);
        cycle_a(0, 0, 0, '0, 0, '0, 1, 5'd31, 32'h5A5A_5A5A);
        n = 0;
        while (ifa.init_busy && n < 200) begin
            n++;
            idle_a(1);
        end
        idle_a(2);
        cycle_a(0, 0, 1, 5'd31, 1, 5'd31, 0, '0, '0);
        idle_a(3);

        cycle_a(0, 1, 0, '0, 0, '0, 0, '0, '0);
        idle_a(10);
        cycle_a(1, 0, 0, '0, 0, '0, 0, '0, '0);
        cycle_a(1, 0, 0, '0, 0, '0, 0, '0, '0);
        cycle_a(0, 0, 0, '0, 0, '0, 0, '0, '0);
        count_busy_a("a_restart_cycles");
        for (int i = 0; i < 100; i++) begin
            r = $urandom;
            cycle_a(0, 1'b0, r[0], 5'(r[10:8]), r[2], 5'(r[13:11]), r[4], 5'(r[23:21]), $urandom);
        end
        idle_a(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/toysram_nr1w_ctl.md
TOYSRAM_NR1W_CTL -- requirements
Module: toysram_nr1w_ctl

Interface
REQ-001 Param WIDTH, default 32, data bits per word; 8..64.
REQ-002 Param DEPTH, default 32, words; power of two, 16..256; AW = log2(DEPTH).
REQ-003 Param LATCHRD, default 1, 1 = registered read data, 0 = unregistered.
REQ-004 Port clk  in  1  sole clock, all state on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port init_req  in  1  single-cycle pulse requesting array zero-initialisation.
REQ-007 Port init_busy  out  1  high while the init sequencer owns the write port.
REQ-008 Ports rd_enb_0 / rd_enb_1  in  1  read enables, ports 0 and 1.
REQ-009 Ports rd_adr_0 / rd_adr_1  in  [0:AW-1]  read addresses; bit 0 is the MSB.
REQ-010 Ports rd_dat_0 / rd_dat_1  out  [0:WIDTH-1]  read data.
REQ-011 Ports rd_vld_0 / rd_vld_1  out  1  read data valid, aligned with rd_dat.
REQ-012 Ports wr_enb_0  in  1; wr_adr_0  in  [0:AW-1]; wr_dat_0  in  [0:WIDTH-1]  write port.

Function
REQ-013 All rd/wr enables, addresses and write data SHALL be captured in input registers on every clk edge.
REQ-014 Storage SHALL be a DEPTH x WIDTH behavioural array; the write commits on the edge after input capture.
REQ-015 Read latency from input-capture edge SHALL be 1 cycle with LATCHRD=0 (array output driven from registered address) and 2 cycles with LATCHRD=1.
REQ-016 rd_vld_x SHALL equal the captured rd_enb_x delayed by the same latency as rd_dat_x.
REQ-017 With LATCHRD=1, rd_dat_x SHALL hold its last value when rd_vld_x is 0; with LATCHRD=0 its value when rd_vld_x is 0 is don't-care.
REQ-018 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-019 Same-cycle read and write to the same captured address SHALL return pre-write data (read-before-write) unless WR_BYPASS_EN is defined.
REQ-020 Init FSM states: IDLE, INIT, DONE; reset release enters INIT; IDLE->INIT on init_req; INIT writes zero to address cnt, cnt increments 0..DEPTH-1; INIT->DONE after address DEPTH-1; DONE->IDLE unconditionally.
REQ-021 init_busy SHALL be high in INIT and DONE; init takes exactly DEPTH+1 cycles.
REQ-022 During init_busy, captured user writes SHALL be dropped and captured reads SHALL produce rd_vld_x = 0.
REQ-023 init_req while init_busy SHALL be ignored; the counter SHALL not wrap past DEPTH-1.

Reset
REQ-024 Reset SHALL asynchronously clear all input registers, rd_dat_x to 0, rd_vld_x to 0, cnt to 0, and force FSM to INIT with init_busy = 1.
REQ-025 Reset asserted mid-init SHALL restart initialisation from address 0 after release.
REQ-026 Array contents SHALL not be reset directly; only the init sequence clears them.

Configuration
REQ-027 Macro WR_BYPASS_EN: when defined, a read whose captured address equals a captured valid write address in the same cycle SHALL return the write data; when undefined, REQ-019 applies.
REQ-028 Bypass SHALL apply to each read port independently and SHALL NOT apply to init-sequencer writes.

Verification
REQ-029 Reset pulse, then idle -> init_busy high exactly DEPTH+1=33 cycles; all 32 addresses then read 0 on both ports.
REQ-030 Write adr 5 = 0xDEADBEEF, next cycle read adr 5 on port 0 and port 1 -> both return 0xDEADBEEF with rd_vld at latency 2 (LATCHRD=1).
REQ-031 Same-cycle write adr 7 = 0x12345678 (old 0) and read adr 7 -> returns 0 without WR_BYPASS_EN, 0x12345678 with it; next read returns 0x12345678.
REQ-032 init_req while array holds data at adr 31, user write issued during busy -> write dropped, adr 31 reads 0 after init.
REQ-033 Reset asserted at init cycle 10 -> init_busy stays high, restarts, completes DEPTH+1 cycles after release.
REQ-034 WIDTH=64, DEPTH=256, LATCHRD=0: write adr 255 = all-ones, read -> all-ones at latency 1.
